// File: rtl/sram_pkg.sv
// Shared constants and helpers for the SRAM responder: address mapping,
// confreg window offsets and byte-lane merging.
package sram_pkg;

  localparam logic [15:0] CONF_BASE_HI = 16'h1faf;
  localparam logic [15:0] OFF_LED      = 16'hf000;
  localparam logic [15:0] OFF_SWITCH   = 16'hf004;
  localparam logic [15:0] OFF_TIMER    = 16'he000;

  // kseg0 and kseg1 collapse onto the same physical location.
  function automatic logic [31:0] phys_addr(input logic [31:0] addr);
    return addr & 32'h1fff_ffff;
  endfunction

  function automatic logic is_conf(input logic [31:0] pa);
    return pa[31:16] == CONF_BASE_HI;
  endfunction

  function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  wen);
    logic [31:0] merged;
    for (int i = 0; i < 4; i++) begin
      merged[8*i +: 8] = wen[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/sram_confreg.sv
// Configuration-register window: LED register, free-running TIMER and a
// two-flop synchronizer for the board switches, with registered read data.
module sram_confreg
  import sram_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [3:0]  wen,
  input  logic [15:0] offset,
  input  logic [31:0] wdata,
  input  logic [7:0]  switch,
  output logic [31:0] rdata,
  output logic [15:0] led
);

  logic [7:0]  sw_meta;
  logic [7:0]  sw_sync;
  logic [31:0] timer;
  logic [31:0] read_word;
  logic [15:0] led_next;
  logic        wr;
  logic        led_we;
  logic        timer_we;

  assign wr       = en & (|wen);
  assign led_we   = wr & (offset == OFF_LED);
  assign timer_we = wr & (offset == OFF_TIMER);

  // Only the low two byte lanes reach the 16-bit LED register.
  assign led_next = {wen[1] ? wdata[15:8] : led[15:8],
                     wen[0] ? wdata[7:0]  : led[7:0]};

  always_comb begin
    read_word = 32'h0;
    case (offset)
      OFF_LED:    read_word = {16'h0, led};
      OFF_SWITCH: read_word = {24'h0, sw_sync};
      OFF_TIMER:  read_word = timer;
      default:    read_word = 32'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sw_meta <= 8'h0;
      sw_sync <= 8'h0;
      timer   <= 32'h0;
      led     <= 16'h0;
      rdata   <= 32'h0;
    end else begin
      sw_meta <= switch;
      sw_sync <= sw_meta;
      // A software write to the timer takes priority over the tick.
      timer   <= timer_we ? byte_merge(timer, wdata, wen) : timer + 32'd1;
      if (led_we) begin
        led <= led_next;
      end
      if (en) begin
        rdata <= read_word;
      end
    end
  end

endmodule

// File: rtl/sram_responder.sv
// Memory-side responder for the CPU instruction and data SRAM ports: a unified
// read-first word store plus the confreg window, both with one-cycle latency.
module sram_responder
  import sram_pkg::*;
#(
  parameter int DEPTH_LOG2 = 16,
  parameter     INIT_FILE  = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_sram_en,
  input  logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_rdata,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  input  logic [7:0]  switch,
  output logic [15:0] led
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [31:0] mem [0:DEPTH-1];

  logic [31:0]           i_pa;
  logic [31:0]           d_pa;
  logic                  i_conf;
  logic                  d_conf;
  logic [DEPTH_LOG2-1:0] i_idx;
  logic [DEPTH_LOG2-1:0] d_idx;
  logic                  store_we;
  logic                  conf_en;
  logic [31:0]           conf_rdata;
  logic [31:0]           d_mem_q;
  logic                  d_conf_q;
  logic                  unused_addr_bits;

  assign i_pa   = phys_addr(inst_sram_addr);
  assign d_pa   = phys_addr(data_sram_addr);
  assign i_conf = is_conf(i_pa);
  assign d_conf = is_conf(d_pa);
  assign i_idx  = i_pa[DEPTH_LOG2+1:2];
  assign d_idx  = d_pa[DEPTH_LOG2+1:2];

  // Upper bits above the store index alias, and the byte offset is ignored.
  assign unused_addr_bits = ^{i_pa, d_pa};

  // A request in the reset cycle is dropped, so writes are gated by reset.
  assign store_we = data_sram_en & (|data_sram_wen) & ~d_conf & ~reset;
  assign conf_en  = data_sram_en & d_conf & ~reset;

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (store_we && data_sram_wen[i]) begin
        mem[d_idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
      end
    end
  end

  // Read registers sample the array before this edge's write lands (read-first).
  always_ff @(posedge clk) begin
    if (reset) begin
      inst_sram_rdata <= 32'h0;
      d_mem_q         <= 32'h0;
      d_conf_q        <= 1'b0;
    end else begin
      if (inst_sram_en) begin
        inst_sram_rdata <= i_conf ? 32'h0 : mem[i_idx];
      end
      if (data_sram_en) begin
        d_conf_q <= d_conf;
        if (!d_conf) begin
          d_mem_q <= mem[d_idx];
        end
      end
    end
  end

  sram_confreg u_confreg (
    .clk    (clk),
    .reset  (reset),
    .en     (conf_en),
    .wen    (data_sram_wen),
    .offset (d_pa[15:0]),
    .wdata  (data_sram_wdata),
    .switch (switch),
    .rdata  (conf_rdata),
    .led    (led)
  );

  assign data_sram_rdata = d_conf_q ? conf_rdata : d_mem_q;

endmodule

// File: tb/tb_sram_responder.sv
// Scoreboard bench for sram_responder: a behavioural memory/confreg model
// predicts both rdata ports and the LED output for every clock cycle.
module tb_sram_responder;

  localparam int DL2 = 10;
  localparam int WORDS = 1 << DL2;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_sram_en;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_rdata;
  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;
  logic [7:0]  switch;
  logic [15:0] led;

  always #5 clk = ~clk;

  sram_responder #(.DEPTH_LOG2(DL2)) dut (
    .clk             (clk),
    .reset           (reset),
    .inst_sram_en    (inst_sram_en),
    .inst_sram_addr  (inst_sram_addr),
    .inst_sram_rdata (inst_sram_rdata),
    .data_sram_en    (data_sram_en),
    .data_sram_wen   (data_sram_wen),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata),
    .data_sram_rdata (data_sram_rdata),
    .switch          (switch),
    .led             (led)
  );

  // Scoreboard queues, one entry per clock cycle.
  logic [31:0] exp_d_q[$];
  logic [31:0] exp_i_q[$];
  logic [15:0] exp_led_q[$];
  int checks = 0;
  int passed = 0;
  logic chk_on = 1'b0;

  // Reference model state.
  logic [31:0] mem_m [0:WORDS-1];
  logic [15:0] led_m = 16'h0;
  logic [31:0] timer_m = 32'h0;
  logic [7:0]  pin_1ago = 8'h0;
  logic [7:0]  pin_2ago = 8'h0;
  logic [31:0] last_d = 32'h0;
  logic [31:0] last_i = 32'h0;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  be);
    logic [31:0] mask;
    mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    return (old_w & ~mask) | (new_w & mask);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
  endtask

  // Drive one clock cycle of requests and advance the model across that edge.
  task automatic step(input logic rst, input logic d_en, input logic [3:0] wen,
                      input logic [31:0] daddr, input logic [31:0] wdata,
                      input logic i_en, input logic [31:0] iaddr);
    logic [31:0] dpa, ipa, dexp, iexp, tmp;
    logic        dconf, iconf, dwr;
    logic [15:0] off;
    reset           = rst;
    data_sram_en    = d_en;
    data_sram_wen   = wen;
    data_sram_addr  = daddr;
    data_sram_wdata = wdata;
    inst_sram_en    = i_en;
    inst_sram_addr  = iaddr;
    dpa   = {3'b000, daddr[28:0]};
    ipa   = {3'b000, iaddr[28:0]};
    dconf = (dpa[31:16] == 16'h1faf);
    iconf = (ipa[31:16] == 16'h1faf);
    off   = dpa[15:0];
    dwr   = d_en && (wen != 4'b0000);
    if (rst) begin
      dexp = 32'h0;
      iexp = 32'h0;
    end else begin
      dexp = last_d;
      iexp = last_i;
      if (d_en) begin
        if (dconf) begin
          if (off == 16'hf000)      dexp = {16'h0, led_m};
          else if (off == 16'hf004) dexp = {24'h0, pin_2ago};
          else if (off == 16'he000) dexp = timer_m;
          else                      dexp = 32'h0;
        end else begin
          dexp = mem_m[dpa[11:2]];
        end
      end
      if (i_en) iexp = iconf ? 32'h0 : mem_m[ipa[11:2]];
    end
    @(posedge clk);
    if (rst) begin
      led_m    = 16'h0;
      timer_m  = 32'h0;
      pin_1ago = 8'h0;
      pin_2ago = 8'h0;
    end else begin
      pin_2ago = pin_1ago;
      pin_1ago = switch;
      if (dwr && !dconf) mem_m[dpa[11:2]] = merge_bytes(mem_m[dpa[11:2]], wdata, wen);
      if (dwr && dconf && off == 16'he000) timer_m = merge_bytes(timer_m, wdata, wen);
      else timer_m = timer_m + 32'd1;
      if (dwr && dconf && off == 16'hf000) begin
        tmp   = merge_bytes({16'h0, led_m}, wdata, {2'b00, wen[1:0]});
        led_m = tmp[15:0];
      end
    end
    last_d = dexp;
    last_i = iexp;
    exp_d_q.push_back(dexp);
    exp_i_q.push_back(iexp);
    exp_led_q.push_back(led_m);
    chk_on = 1'b1;
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic dwrite(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    step(1'b0, 1'b1, be, a, d, 1'b0, 32'h0);
  endtask

  task automatic dread(input logic [31:0] a);
    step(1'b0, 1'b1, 4'h0, a, 32'h0, 1'b0, 32'h0);
  endtask

  // Monitor: every falling edge after a driven cycle checks the presented outputs.
  always @(negedge clk) begin
    if (chk_on) begin
      if (exp_d_q.size() == 0 || exp_i_q.size() == 0 || exp_led_q.size() == 0) begin
        checks++;
        $display("FAIL scoreboard_underflow: got empty queue expected entry at %0t", $time);
      end else begin
        check("data_rdata", data_sram_rdata, exp_d_q.pop_front());
        check("inst_rdata", inst_sram_rdata, exp_i_q.pop_front());
        check("led", {16'h0, led}, {16'h0, exp_led_q.pop_front()});
      end
    end
  end

  initial begin
    logic [31:0] a, d, ia;
    logic [3:0]  be;
    int          sel;
    switch = 8'h0;
    step(1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0);

    // Fill the store so every later read has a known expectation.
    for (int i = 0; i < WORDS; i++) dwrite(32'h8000_0000 + 32'(i) * 4, $urandom, 4'hf);

    // Round trip through the kseg1 alias, then partial byte lanes.
    dwrite(32'h8000_0100, 32'h1122_3344, 4'hf);
    dread(32'hA000_0100);
    dwrite(32'h8000_0100, 32'hAABB_CCDD, 4'b0101);
    dread(32'h8000_0100);
    dread(32'h0000_0100 + 32'(WORDS) * 4);

    // Read-first collision between the data write and the instruction read.
    step(1'b0, 1'b1, 4'hf, 32'h8000_0200, 32'hDEAD_BEEF, 1'b1, 32'h8000_0200);
    step(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 32'h8000_0200);
    step(1'b0, 1'b1, 4'h0, 32'h8000_0200, 32'h0, 1'b1, 32'hBFAF_F000);

    // Confreg LED, SWITCH and an unmapped offset.
    dwrite(32'hBFAF_F000, 32'h0000_00A5, 4'hf);
    switch = 8'h3C;
    idle();
    idle();
    idle();
    dread(32'hBFAF_F004);
    dread(32'hBFAF_F100);
    dread(32'hBFAF_F000);

    // TIMER load and wrap.
    dwrite(32'hBFAF_E000, 32'hFFFF_FFFE, 4'hf);
    dread(32'hBFAF_E000);
    dread(32'hBFAF_E000);
    dread(32'hBFAF_E000);

    // Reset in the middle of a data write.
    dwrite(32'hBFAF_F000, 32'h0000_00FF, 4'hf);
    dread(32'h8000_0300);
    step(1'b1, 1'b1, 4'hf, 32'h8000_0300, 32'h1234_5678, 1'b1, 32'h8000_0300);
    dread(32'h8000_0300);
    dread(32'hBFAF_E000);
    dread(32'hBFAF_E000);

    // Randomized mix of store and confreg traffic on both ports.
    for (int n = 0; n < 600; n++) begin
      sel = $urandom_range(0, 9);
      if (sel < 6) begin
        a = ($urandom & 32'h0fff_ffff) | (($urandom_range(0, 1) == 1) ? 32'hA000_0000 : 32'h8000_0000);
      end else begin
        case ($urandom_range(0, 3))
          0:       a = 32'hBFAF_F000;
          1:       a = 32'hBFAF_F004;
          2:       a = 32'hBFAF_E000;
          default: a = 32'hBFAF_0000 | ($urandom & 32'h0000_fffc);
        endcase
      end
      ia = ($urandom_range(0, 7) == 0) ? 32'hBFAF_F000 : (($urandom & 32'h0fff_ffff) | 32'h8000_0000);
      if ($urandom_range(0, 4) == 0) ia = a;
      be = ($urandom_range(0, 1) == 1) ? 4'(($urandom)) : 4'h0;
      d  = $urandom;
      if ($urandom_range(0, 9) == 0) switch = 8'($urandom);
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0), be, a, d,
           ($urandom_range(0, 3) != 0), ia);
    end

    @(negedge clk);
    #1;
    chk_on = 1'b0;
    checks++;
    if (exp_d_q.size() == 0 && exp_i_q.size() == 0 && exp_led_q.size() == 0) passed++;
    else $display("FAIL scoreboard_drain: got %0d entries left expected 0", exp_d_q.size());
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
